// File: rtl/sliced_adder_64.sv
// 64-bit adder that reuses one 16-bit carry-lookahead slice over four cycles.
// The carry between slices is held in a register.

module CLA_16_bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic        gacc;
    logic        pacc;

    // Four 4-bit lookahead groups; group carries ripple from one group to the next
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        gacc = 1'b0;
        pacc = 1'b1;
        c[0] = cin;
        for (int grp = 0; grp < 4; grp++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gacc = g[grp*4+i] | (p[grp*4+i] & gacc);
                pacc = p[grp*4+i] & pacc;
                c[grp*4+i+1] = gacc | (pacc & c[grp*4]);
            end
        end
        sum  = p ^ c[15:0];
        cout = c[16];
    end
endmodule

module sliced_adder_64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        cout,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic        carry_r;
    logic        load;
    logic [15:0] sl_a;
    logic [15:0] sl_b;
    logic [15:0] sl_sum;
    logic        sl_cout;

    CLA_16_bit_ripple u_cla (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_r),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        sl_a = a_r[15:0];
        sl_b = b_r[15:0];
        case (cnt)
            2'd0: begin sl_a = a_r[15:0];  sl_b = b_r[15:0];  end
            2'd1: begin sl_a = a_r[31:16]; sl_b = b_r[31:16]; end
            2'd2: begin sl_a = a_r[47:32]; sl_b = b_r[47:32]; end
            2'd3: begin sl_a = a_r[63:48]; sl_b = b_r[63:48]; end
            default: begin sl_a = a_r[15:0]; sl_b = b_r[15:0]; end
        endcase
    end

    // New operands are accepted only when no addition is in flight
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == 2'd3) state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= cin;
                cnt     <= 2'd0;
            end else if (state == RUN) begin
                case (cnt)
                    2'd0: sum[15:0]  <= sl_sum;
                    2'd1: sum[31:16] <= sl_sum;
                    2'd2: sum[47:32] <= sl_sum;
                    2'd3: sum[63:48] <= sl_sum;
                    default: sum[15:0] <= sl_sum;
                endcase
                carry_r <= sl_cout;
                cnt     <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    cout     <= sl_cout;
                    overflow <= (a_r[63] == b_r[63]) && (sl_sum[15] != a_r[63]);
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_sliced_adder_64.sv
// Directed bench for sliced_adder_64: latency, carry chains, overflow,
// busy protection, mid-run reset and back-to-back operation.

module tb_sliced_adder_64;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;

    int compared;
    int mismatched;

    sliced_adder_64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; start is sampled on the next rising edge
    task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 12);
        checkOutput(tag, 64'(n), 64'(expCycles));
    endtask

    task automatic countDone(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput(tag, 64'(pulses), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [63:0] va, input logic [63:0] vb,
                         input logic vc, input logic [63:0] es, input logic ec, input logic eo);
        applyStimulus(va, vb, vc);
        checkOutput({tag, " busy"}, 64'(busy), 64'd1);
        waitDone({tag, " latency"}, 4);
        checkOutput({tag, " sum"}, sum, es);
        checkOutput({tag, " cout"}, 64'(cout), 64'(ec));
        checkOutput({tag, " ovf"}, 64'(overflow), 64'(eo));
        checkOutput({tag, " busy@done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst done", 64'(done), 64'd0);
        checkOutput("rst sum", sum, 64'd0);
        checkOutput("rst cout", 64'(cout), 64'd0);
        checkOutput("rst ovf", 64'(overflow), 64'd0);

        // Start accepted on the very first edge with reset released
        rst_n = 1'b1;
        runOp("fullcarry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fullcarry pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("hold cout", 64'(cout), 64'd1);

        runOp("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("hold sum", sum, 64'h8000_0000_0000_0000);
        checkOutput("hold ovf", 64'(overflow), 64'd1);

        runOp("cinpath", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        runOp("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        runOp("midcarry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
              64'h0001_0000_0001_0000, 1'b0, 1'b0);
        @(negedge clk);

        // Busy protection: a start while running must not reload operands
        applyStimulus(64'd5, 64'd3, 1'b0);
        a     = 64'd100;
        b     = 64'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 64'h1234_5678;
        b     = 64'h9ABC_DEF0;
        cin   = 1'b1;
        waitDone("busyprot latency", 3);
        checkOutput("busyprot sum", sum, 64'd8);
        countDone("busyprot extra done", 6);

        // Reset sampled at edge N+2 aborts the run
        applyStimulus(64'h1111, 64'h2222, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        checkOutput("midrst done", 64'(done), 64'd0);
        checkOutput("midrst sum", sum, 64'd0);
        checkOutput("midrst cout", 64'(cout), 64'd0);
        checkOutput("midrst ovf", 64'(overflow), 64'd0);
        countDone("midrst no done", 6);
        rst_n = 1'b1;
        runOp("afterrst", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back: new start held during the done cycle
        runOp("b2b first", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);
        applyStimulus(64'd10, 64'd20, 1'b0);
        checkOutput("b2b busy", 64'(busy), 64'd1);
        waitDone("b2b latency", 4);
        checkOutput("b2b sum", sum, 64'd30);
        countDone("b2b extra done", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sliced_adder_64.md
SLICED_ADDER_64 -- requirements
Module: sliced_adder_64

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 64 bits and the slice width at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  64  operand A; captured when start is accepted.
REQ-006 b  input  64  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in to bit 0; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse marking the result as valid.
REQ-010 sum  output  64  result; held stable from done until the next accepted start.
REQ-011 cout  output  1  carry out of bit 63.
REQ-012 overflow  output  1  two's-complement signed overflow of the 64-bit add.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin using one instance of the existing CLA_16_bit_ripple adder (ports a, b, cin, cout, sum), applied to one 16-bit slice per cycle.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, plus a 2-bit slice counter.
REQ-015 IDLE to RUN: when start=1 is sampled, the block SHALL latch a, b and cin into internal registers, clear the counter to 0 and set busy=1.
REQ-016 RUN: on each edge, the block SHALL write slice sum[16k+15:16k] for k = counter, register the slice carry-out as the carry-in of slice k+1, and increment the counter.
REQ-017 RUN to DONE: on the edge that writes slice 3, the block SHALL set cout and overflow, and drive done=1 and busy=0 for exactly the following cycle.
REQ-018 Overflow SHALL equal (a[63]==b[63]) && (sum[63]!=a[63]), evaluated on the latched operands.
REQ-019 Latency: with start sampled at edge N, slices are written at edges N+1 through N+4, and done is high during the cycle after edge N+4.
REQ-020 DONE to IDLE SHALL occur on the next edge when start=0; when start=1 the block SHALL go DONE to RUN and accept new operands back-to-back.
REQ-021 start while busy=1 SHALL be ignored; a, b and cin SHALL NOT affect an in-flight operation.
REQ-022 sum, cout and overflow SHALL hold their value through IDLE.
REQ-023 While RUN, sum SHALL update slice-wise and is valid only when done=1.
REQ-024 Wrap-around: a carry chain crossing all four slices (e.g. a all ones, b=1) SHALL propagate correctly through the registered inter-slice carry.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, counter 0, busy=0, done=0, sum=0, cout=0, overflow=0 and the internal operand registers to 0.
REQ-026 Reset SHALL take priority over start and SHALL abort an in-flight operation without producing a done pulse.
REQ-027 The first start SHALL be accepted on the first edge at which rst_n=1 and start=1.

Verification
REQ-028 Full carry propagation: a=FFFF_FFFF_FFFF_FFFF, b=0000_0000_0000_0001, cin=0 -> sum=0, cout=1, overflow=0, done at edge N+4.
REQ-029 Signed overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=8000_0000_0000_0000, cout=0, overflow=1.
REQ-030 Carry-in path: a=0123_4567_89AB_CDEF, b=FEDC_BA98_7654_3210, cin=1 -> sum=0, cout=1, overflow=0.
REQ-031 Busy protection: start a=5, b=3; while busy, pulse start with a=100, b=100 and change the operands -> single done, sum=8.
REQ-032 Reset mid-run: start, then rst_n=0 at edge N+2 -> all outputs 0, no done pulse; a following start with a=1, b=1 -> sum=2.
REQ-033 Back-to-back: hold start=1 during the done cycle with a=10, b=20 -> second done exactly 5 cycles after the first, sum=30.
